gshare_branch_predicter: RTL

//  Next-generation predictor for the IF stage: gshare direction predictor plus return-address stack (RAS).
//  - Direction: 2-bit counter PHT indexed by PC XOR a speculative global history register (GHR).
//  - Same-cycle outputs: taken flag, full target address, and a GHR snapshot that travels with the instruction to the ROB.
//  - The ROB commit path trains the PHT and, on mispredict, repairs the GHR.

---
 rtl/gshare_branch_predicter_if.sv | 29 ++
 rtl/gshare_branch_predicter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predicter_if.sv
// Fetch/commit-side signal bundle for the gshare + RAS predictor.
// master = IF stage and ROB commit logic, slave = predictor.
interface gshare_branch_predicter_if #(
  parameter int GHR_W = 8
);
  logic             query_valid;
  logic [31:0]      input_pc;
  logic [31:0]      input_inst;
  logic             is_jump_flag;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             is_update_flag;
  logic             jumped_flag;
  logic [31:0]      rob_pc;
  logic [GHR_W-1:0] rob_ghr;
  logic             mispredict_flag;

  modport master (
    output query_valid, input_pc, input_inst,
    output is_update_flag, jumped_flag, rob_pc, rob_ghr, mispredict_flag,
    input  is_jump_flag, pred_target, pred_ghr
  );

  modport slave (
    input  query_valid, input_pc, input_inst,
    input  is_update_flag, jumped_flag, rob_pc, rob_ghr, mispredict_flag,
    output is_jump_flag, pred_target, pred_ghr
  );
endinterface

// File: rtl/gshare_branch_predicter.sv
// Gshare direction predictor with a return-address stack for the IF stage.
// Zero-latency prediction; PHT trained and GHR repaired from the ROB commit path.
module gshare_branch_predicter #(
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  gshare_branch_predicter_if.slave bus
);
  localparam int PHT_N     = 1 << PHT_IDX_W;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    logic [1:0] n;
    n = c;
    if (up && c != 2'b11) n = c + 2'b01;
    else if (!up && c != 2'b00) n = c - 2'b01;
    return n;
  endfunction

  function automatic logic [GHR_W-1:0] shift_hist(input logic [GHR_W-1:0] h, input logic b);
    logic [GHR_W-1:0] n;
    n    = h << 1;
    n[0] = b;
    return n;
  endfunction

  logic [1:0]           pht [PHT_N];
  logic [GHR_W-1:0]     ghr;
  logic [31:0]          ras [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0]     ras_cnt;

  logic [6:0]           opcode;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic                 is_br;
  logic                 is_jal;
  logic                 is_jalr;
  logic                 is_ret;
  logic [31:0]          j_imm;
  logic [31:0]          b_imm;
  logic [31:0]          pc_plus4;
  logic [PHT_IDX_W-1:0] pred_idx;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic [RAS_PTR_W-1:0] top_ptr;
  logic                 pred_taken;
  logic [31:0]          pred_tgt;
  logic                 spec_en;
  logic                 do_push;
  logic                 do_repl;
  logic                 do_pop;
  logic                 unused_bits;

  assign opcode   = bus.input_inst[6:0];
  assign rd       = bus.input_inst[11:7];
  assign rs1      = bus.input_inst[19:15];
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_ret   = is_jalr && (rd == 5'd0) && is_link(rs1);
  assign j_imm    = {{11{bus.input_inst[31]}}, bus.input_inst[31], bus.input_inst[19:12],
                     bus.input_inst[20], bus.input_inst[30:21], 1'b0};
  assign b_imm    = {{19{bus.input_inst[31]}}, bus.input_inst[31], bus.input_inst[7],
                     bus.input_inst[30:25], bus.input_inst[11:8], 1'b0};
  assign pc_plus4 = bus.input_pc + 32'd4;
  assign pred_idx = bus.input_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign upd_idx  = bus.rob_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bus.rob_ghr);
  assign top_ptr  = ras_ptr - RAS_PTR_W'(1);

  // rob_pc bits outside the PHT index window carry no information for training
  assign unused_bits = ^{bus.rob_pc[31:PHT_IDX_W+2], bus.rob_pc[1:0]};

  always_comb begin
    pred_taken = 1'b0;
    pred_tgt   = pc_plus4;
    if (is_jal) begin
      pred_taken = 1'b1;
      pred_tgt   = bus.input_pc + j_imm;
    end else if (is_br) begin
      pred_taken = pht[pred_idx][1];
      pred_tgt   = bus.input_pc + b_imm;
    end else if (is_ret && ras_cnt != '0) begin
      pred_taken = 1'b1;
      pred_tgt   = ras[top_ptr];
    end
  end

  assign bus.is_jump_flag = pred_taken;
  assign bus.pred_target  = pred_tgt;
  assign bus.pred_ghr     = ghr;

  // A mispredict cycle flushes the fetched instruction, so its RAS/GHR effects are dropped
  assign spec_en = rdy && bus.query_valid && !bus.mispredict_flag;
  assign do_push = spec_en && (is_jal || is_jalr) && is_link(rd);
  assign do_repl = do_push && is_jalr && is_link(rs1) && (rd != rs1) && (ras_cnt != '0);
  assign do_pop  = spec_en && is_ret && (ras_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (rdy && bus.is_update_flag) begin
      pht[upd_idx] <= sat_step(pht[upd_idx], bus.jumped_flag);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (rdy) begin
      if (bus.mispredict_flag)
        ghr <= bus.is_update_flag ? shift_hist(bus.rob_ghr, bus.jumped_flag) : bus.rob_ghr;
      else if (bus.query_valid && is_br)
        ghr <= shift_hist(ghr, pred_taken);
    end
  end

  // Circular stack: ras_ptr is the next free slot, so a push when full lands on the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_repl) begin
      ras[top_ptr] <= pc_plus4;
    end else if (do_push) begin
      ras[ras_ptr] <= pc_plus4;
      ras_ptr      <= ras_ptr + RAS_PTR_W'(1);
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (do_pop) begin
      ras_ptr <= top_ptr;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end
endmodule
